ram_lsu_ctrl: RTL and testbench

- Load/store initiator that turns single core memory requests into pin-level accesses on the data RAM's CS/WR/OE interface.
- Accepts one request at a time from the RISC-V datapath over a valid/ready handshake.
- Handles byte, half and word accesses. Sub-word stores use read-modify-write because the RAM has no byte enables.
- Returns a one-cycle response pulse carrying sign- or zero-extended load data, or an error flag.

---
 rtl/ram_lsu_ctrl.sv | 158 +++++++++++++++
 tb/tb_ram_lsu_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu_ctrl.sv
// rtl/ram_lsu_ctrl.sv - load/store initiator for a CS/WR/OE data RAM, read-modify-write for sub-word stores
// LSU_RD_WAIT_EN stretches the RAM read to two cycles (RD, RD2).
module ram_lsu_ctrl #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32,
  localparam int AW            = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic                   REQ_WE,
  input  logic [1:0]             REQ_SIZE,
  input  logic                   REQ_UNSIGNED,
  input  logic [AW+1:0]          REQ_ADDR,
  input  logic [TAM_PALABRA-1:0] REQ_WDATA,
  output logic                   RSP_VALID,
  output logic [TAM_PALABRA-1:0] RSP_RDATA,
  output logic                   RSP_ERR,
  output logic                   MEM_CS,
  output logic                   MEM_WR,
  output logic                   MEM_OE,
  output logic [AW-1:0]          MEM_ADDRESS,
  output logic [TAM_PALABRA-1:0] MEM_DATA_IN,
  input  logic [TAM_PALABRA-1:0] MEM_DATA_OUT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RD2  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [AW+1:0]          addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic                   we_q, we_d;
  logic                   uns_q, uns_d;
  logic                   err_q, err_d;
  logic [TAM_PALABRA-1:0] wdata_q, wdata_d;
  logic [TAM_PALABRA-1:0] rdword_q, rdword_d;

  logic                   req_bad;
  logic [TAM_PALABRA-1:0] lane_w;
  logic [TAM_PALABRA-1:0] load_w;
  logic [TAM_PALABRA-1:0] store_w;

  always_comb begin
    req_bad = (REQ_SIZE == 2'b11) ||
              ((REQ_SIZE == 2'b01) && REQ_ADDR[0]) ||
              ((REQ_SIZE == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    uns_d    = uns_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    rdword_d = rdword_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && ready_q) begin
          addr_d  = REQ_ADDR;
          size_d  = REQ_SIZE;
          we_d    = REQ_WE;
          uns_d   = REQ_UNSIGNED;
          wdata_d = REQ_WDATA;
          err_d   = req_bad;
          if (req_bad)
            state_d = S_RSP;
          else if (REQ_WE && (REQ_SIZE == 2'b10))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
`ifdef LSU_RD_WAIT_EN
        state_d = S_RD2;
`else
        rdword_d = MEM_DATA_OUT;
        state_d  = we_q ? S_WR : S_RSP;
`endif
      end
      S_RD2: begin
        rdword_d = MEM_DATA_OUT;
        state_d  = we_q ? S_WR : S_RSP;
      end
      S_WR:    state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdword_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      rdword_q <= rdword_d;
    end
  end

  // Valid halves have ADDR[0]=0, so a byte-granular shift serves both sub-word sizes.
  always_comb begin
    lane_w  = rdword_q >> {addr_q[1:0], 3'b000};
    load_w  = rdword_q;
    store_w = wdata_q;
    case (size_q)
      2'b00: begin
        load_w  = {{(TAM_PALABRA-8){~uns_q & lane_w[7]}}, lane_w[7:0]};
        store_w = rdword_q;
        store_w[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_w  = {{(TAM_PALABRA-16){~uns_q & lane_w[15]}}, lane_w[15:0]};
        store_w = rdword_q;
        store_w[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    REQ_READY   = ready_q;
    MEM_CS      = (state_q == S_RD) || (state_q == S_RD2) || (state_q == S_WR);
    MEM_OE      = (state_q == S_RD) || (state_q == S_RD2);
    MEM_WR      = (state_q == S_WR);
    MEM_ADDRESS = addr_q[AW+1:2];
    MEM_DATA_IN = (state_q == S_WR) ? store_w : '0;
    RSP_VALID   = (state_q == S_RSP);
    RSP_ERR     = (state_q == S_RSP) && err_q;
    RSP_RDATA   = ((state_q == S_RSP) && !we_q && !err_q) ? load_w : '0;
  end

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// tb/tb_ram_lsu_ctrl.sv - self-checking bench for ram_lsu_ctrl against a request-level model and a RAM model
module tb_ram_lsu_ctrl;

`ifdef LSU_RD_WAIT_EN
  localparam int RDL = 2;
`else
  localparam int RDL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_cs, mem_wr, mem_oe;
  logic [9:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;

  always #5 clk = ~clk;

  ram_lsu_ctrl #(.TAM_POSICIONES(1024), .TAM_PALABRA(32)) dut (
    .CLK(clk), .RSTa(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .MEM_CS(mem_cs), .MEM_WR(mem_wr), .MEM_OE(mem_oe),
    .MEM_ADDRESS(mem_address), .MEM_DATA_IN(mem_data_in), .MEM_DATA_OUT(mem_data_out)
  );

  logic [31:0] ram [0:1023];
  always @(posedge clk) if (mem_cs && mem_wr) ram[mem_address] <= mem_data_in;
  assign mem_data_out = (mem_cs && mem_oe && !mem_wr) ? ram[mem_address] : 32'hA5A5_5A5A;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    int          acc;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          err;
  } req_t;

  logic [31:0] model_mem [0:1023];
  req_t        q[$];
  logic [31:0] rsp_log[$];
  int          ncyc = 0;
  int          cur_wr, cur_rd;
  bit          prev_rst = 1'b0;
  int          rsp_count = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  function automatic bit is_err(input logic [1:0] size, input logic [11:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] size,
                                           input bit uns, input logic [11:0] addr);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * int'(addr[1:0]))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * int'(addr[1]))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] old, input logic [1:0] size,
                                            input logic [11:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return wd;
    sh   = (size == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic int latency(input bit we, input logic [1:0] size, input logic [11:0] addr);
    if (is_err(size, addr)) return 1;
    if (!we) return 1 + RDL;
    if (size == 2'd2) return 2;
    return 2 + RDL;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      q.delete();
      chk("cs_in_reset", 32'(mem_cs), 32'd0);
      chk("wr_in_reset", 32'(mem_wr), 32'd0);
      chk("rspv_in_reset", 32'(rsp_valid), 32'd0);
      prev_rst = 1'b0;
    end else begin
      chk("req_ready", 32'(req_ready), 32'((q.size() == 0) && prev_rst));
      if (q.size() == 0) begin
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_mem_cs", 32'(mem_cs), 32'd0);
      end else if (ncyc == q[0].due) begin
        logic [31:0] w, exp_rd;
        w      = model_mem[q[0].addr[11:2]];
        exp_rd = (q[0].err || q[0].we) ? 32'd0 : load_val(w, q[0].size, q[0].uns, q[0].addr);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_mem_cs", 32'(mem_cs), 32'd0);
        chk("wr_cycles", 32'(cur_wr), 32'((!q[0].err && q[0].we) ? 1 : 0));
        chk("rd_cycles", 32'(cur_rd),
            32'((!q[0].err && (!q[0].we || q[0].size != 2'd2)) ? RDL : 0));
        if (!q[0].err && q[0].we)
          model_mem[q[0].addr[11:2]] = store_val(w, q[0].size, q[0].addr, q[0].wdata);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        last_lat   = q[0].due - q[0].acc;
        rsp_log.push_back(rsp_rdata);
        rsp_count++;
        void'(q.pop_front());
      end else begin
        chk("busy_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("busy_mem_cs", 32'(mem_cs), 32'(!q[0].err));
        if (mem_cs) chk("mem_address", 32'(mem_address), 32'(q[0].addr[11:2]));
        if (mem_wr) begin
          chk("mem_data_in", mem_data_in,
              store_val(model_mem[q[0].addr[11:2]], q[0].size, q[0].addr, q[0].wdata));
          cur_wr++;
        end
        if (mem_oe) cur_rd++;
      end
      if (req_valid && req_ready) begin
        req_t e;
        e.acc   = ncyc;
        e.due   = ncyc + latency(req_we, req_size, req_addr);
        e.we    = req_we;
        e.size  = req_size;
        e.uns   = req_unsigned;
        e.addr  = req_addr;
        e.wdata = req_wdata;
        e.err   = is_err(req_size, req_addr);
        q.push_back(e);
        cur_wr = 0;
        cur_rd = 0;
      end
      prev_rst = 1'b1;
    end
  end

  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [11:0] addr, input logic [31:0] wd, input bit hold);
    bit got;
    got          = 1'b0;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic put_word(input int idx, input logic [31:0] v);
    ram[idx]       = v;
    model_mem[idx] = v;
  endtask

  typedef struct {
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] exp;
  } ld_t;

  ld_t ld_tab[6];
  int  n_before;

  initial begin
    for (int i = 0; i < 1024; i++) put_word(i, 32'h1357_0000 + 32'(i));
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_mem_address", 32'(mem_address), 32'd0);
    chk("reset_mem_data_in", mem_data_in, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, 1'b0);
    wait_done();
    chk("wstore_lat", 32'(last_lat), 32'd2);
    chk("wstore_ram", ram[4], 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 1'b0);
    wait_done();
    chk("wload_data", last_rdata, 32'hDEAD_BEEF);
    chk("wload_err", 32'(last_err), 32'd0);
    chk("wload_lat", 32'(last_lat), 32'(1 + RDL));

    put_word(4, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 12'h012, 32'h0000_00AB, 1'b0);
    wait_done();
    chk("bstore_ram", ram[4], 32'h11AB_3344);
    chk("bstore_lat", 32'(last_lat), 32'(2 + RDL));
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 1'b0);
    wait_done();
    chk("bstore_readback", last_rdata, 32'h11AB_3344);

    issue(1'b1, 2'd1, 1'b0, 12'h012, 32'hCAFE_BABE, 1'b0);
    wait_done();
    chk("hstore_ram", ram[4], 32'hBABE_3344);

    put_word(4, 32'h80FF_7F01);
    ld_tab[0] = '{2'd0, 1'b0, 12'h013, 32'hFFFF_FF80};
    ld_tab[1] = '{2'd0, 1'b1, 12'h013, 32'h0000_0080};
    ld_tab[2] = '{2'd1, 1'b0, 12'h010, 32'h0000_7F01};
    ld_tab[3] = '{2'd1, 1'b0, 12'h012, 32'hFFFF_80FF};
    ld_tab[4] = '{2'd1, 1'b1, 12'h012, 32'h0000_80FF};
    ld_tab[5] = '{2'd0, 1'b0, 12'h011, 32'h0000_007F};
    foreach (ld_tab[k]) begin
      issue(1'b0, ld_tab[k].size, ld_tab[k].uns, ld_tab[k].addr, 32'd0, 1'b0);
      wait_done();
      chk($sformatf("load_tab%0d", k), last_rdata, ld_tab[k].exp);
    end

    put_word(5, 32'h0BAD_F00D);
    issue(1'b0, 2'd1, 1'b0, 12'h011, 32'd0, 1'b0);
    wait_done();
    chk("misalign_half_err", 32'(last_err), 32'd1);
    chk("misalign_half_lat", 32'(last_lat), 32'd1);
    issue(1'b1, 2'd2, 1'b0, 12'h016, 32'h1234_5678, 1'b0);
    wait_done();
    chk("misalign_word_err", 32'(last_err), 32'd1);
    chk("misalign_word_ram", ram[5], 32'h0BAD_F00D);
    issue(1'b0, 2'd3, 1'b0, 12'h014, 32'd0, 1'b0);
    wait_done();
    chk("size11_err", 32'(last_err), 32'd1);

    put_word(6, 32'h5566_7788);
    n_before = rsp_count;
    issue(1'b1, 2'd0, 1'b0, 12'h019, 32'h0000_00EE, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_wr) begin
          seen = 1'b1;
          break;
        end
      end
      chk("wr_seen", 32'(seen), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(mem_cs), 32'd0);
    chk("abort_wr", 32'(mem_wr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_ram", ram[6], 32'h5566_7788);
    chk("abort_no_rsp", 32'(rsp_count), 32'(n_before));

    put_word(4, 32'h80FF_7F01);
    n_before = rsp_count;
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 12'h013, 32'd0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 12'h012, 32'd0, 1'b0);
    wait_done();
    chk("b2b_count", 32'(rsp_count - n_before), 32'd3);
    if (rsp_log.size() >= 3) begin
      chk("b2b_rsp0", rsp_log[rsp_log.size() - 3], 32'h80FF_7F01);
      chk("b2b_rsp1", rsp_log[rsp_log.size() - 2], 32'h0000_0080);
      chk("b2b_rsp2", rsp_log[rsp_log.size() - 1], 32'hFFFF_80FF);
    end else begin
      chk("b2b_log_size", 32'(rsp_log.size()), 32'd3);
    end

    for (int i = 0; i < 16; i++) chk($sformatf("ram_final%0d", i), ram[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
